axi_crossbar_wr_arb: RTL
========================

Name: axi_crossbar_wr_arb

Overview:
Write-path arbiter for one slave port of the AXI crossbar switch. It arbitrates round-robin among NUM_MST master-interface AW channels (clock-domain-crossed packed awch/wch/bch buses) and registers the winning AW. It then steers that master's W burst to the slave until wlast, and routes B responses back to the master encoded in the upper ID bits. One write transaction is in flight per slave port at a time.

Parameters:
NUM_MST, 4, number of master requesters (2..4)
AXI_ADDR_W, 32, address field width; the ID field starts at this bit offset in awch
AXI_ID_W, 4, extended ID width; ID[AXI_ID_W-1 -: 2] is the master index
AWCH_W, 53, packed AW width {lock,burst,size,len,id,addr}; len sits at [AXI_ADDR_W+AXI_ID_W +: 4]
WCH_W, 47, packed W width {strb,data,id}
BCH_W, 12, packed B width {resp,id}; ID at [0 +: AXI_ID_W]

Ports:
i_aclk  in  1  switch clock
i_aresetn  in  1  asynchronous active-low reset
m_awvalid  in  NUM_MST  per-master AW valid
m_awready  out  NUM_MST  per-master AW ready
m_awch  in  NUM_MST*AWCH_W  per-master packed AW
m_wvalid  in  NUM_MST  per-master W valid
m_wready  out  NUM_MST  per-master W ready
m_wlast  in  NUM_MST  per-master W last
m_wch  in  NUM_MST*WCH_W  per-master packed W
m_bvalid  out  NUM_MST  per-master B valid
m_bready  in  NUM_MST  per-master B ready
m_bch  out  BCH_W  B payload broadcast to all masters
s_awvalid  out  1  AW valid to slave
s_awready  in  1  AW ready from slave
s_awch  out  AWCH_W  registered AW payload
s_wvalid  out  1  W valid to slave
s_wready  in  1  W ready from slave
s_wlast  out  1  W last
s_wch  out  WCH_W  W payload
s_bvalid  in  1  B valid from slave
s_bready  out  1  B ready to slave
s_bch  in  BCH_W  B payload
o_grant  out  NUM_MST  one-hot current owner, 0 in IDLE
o_err  out  2  sticky error: [0] wlast/len mismatch, [1] B ID out of range

Behaviour:
- Reset, asynchronous: state IDLE; rr_ptr=0; s_awvalid=0; s_awch=0; beat counter=0; o_grant=0; o_err=0. All m_*ready/m_bvalid/s_wvalid are 0 while in IDLE with no request.
- FSM states are IDLE, ADDR and DATA.
- IDLE:
  - Winner = first set m_awvalid bit searching from rr_ptr upward, with wrap.
  - m_awready[winner]=1 combinationally. Capture m_awch[winner] into s_awch, latch the winner index and awlen, set beat counter to 0, set rr_ptr=(winner+1)%NUM_MST.
  - Go to ADDR. With no request, stay in IDLE.
- ADDR:
  - s_awvalid=1. On s_awready, go to DATA.
  - AW latency: master handshake in cycle N, s_awvalid high from N+1.
- DATA:
  - s_wvalid=m_wvalid[g], s_wlast=m_wlast[g], s_wch=m_wch[g], m_wready[g]=s_wready. All other m_wready=0; this is a pure combinational path.
  - Each W handshake increments the beat counter.
  - On a handshake with wlast=1, go to IDLE. If beat counter != awlen at that beat, set o_err[0].
  - If the counter reaches awlen without wlast, set o_err[0]; the burst still ends only on wlast.
- W from the granted master arriving during IDLE or ADDR is held, with m_wready=0. W from non-granted masters is always held off.
- No m_awready is asserted outside IDLE. The next arbitration happens at the earliest in the cycle after the last W handshake.
- B path is combinational and independent of the FSM:
  - sel=s_bch[AXI_ID_W-1 -: 2]; m_bch=s_bch.
  - If sel<NUM_MST: m_bvalid[sel]=s_bvalid and s_bready=m_bready[sel].
  - Otherwise s_bready=1 (drop), and o_err[1] is set on the handshake.
- o_err clears only on reset.

Decomposition:
- A shared package axi_crossbar_pkg holds:
  - the channel-width constants (AWCH_W, WCH_W, BCH_W);
  - the field offsets (ID_LSB=AXI_ADDR_W, LEN_LSB);
  - the master-index width constant;
  - typedef enum {IDLE, ADDR, DATA} wr_arb_state_e.
- One sub-module, axi_crossbar_rr_arb (NUM_REQ, req, ptr -> one-hot gnt, index), is reused by the read-path arbiter.

Test Plan:
1. Single master 1, awlen=3, s_awready=1, s_wready=1 → s_awvalid high 1 cycle after m_awready[1]; 4 W beats forwarded; last carries s_wlast=1; o_err=0; back to IDLE.
2. All 4 masters request simultaneously after reset, each with awlen=0 → grant order 0,1,2,3, then 0 again; o_grant one-hot throughout each transaction.
3. s_awready held low 5 cycles in ADDR → s_awvalid and s_awch stable; m_wready[g]=0 until DATA; no other m_awready asserted.
4. s_wready toggling every cycle during awlen=7 burst → exactly 8 beats, data order preserved; master 2 W pre-presented stays stalled.
5. Master 0 sends wlast on beat 2 with awlen=3 → o_err[0]=1 sticky; FSM returns to IDLE.
6. s_bvalid with ID=4'b1001 and m_bready[2]=1 → m_bvalid=4'b0100; with NUM_MST=2 and ID=4'b1100 → s_bready=1, o_err[1]=1. Assert i_aresetn mid-DATA → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/axi_crossbar_pkg.sv
// Shared constants and types for the AXI crossbar read/write arbiters.
package axi_crossbar_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AWCH_W     = 53;
  localparam int WCH_W      = 47;
  localparam int BCH_W      = 12;

  localparam int ID_LSB     = AXI_ADDR_W;
  localparam int LEN_LSB    = AXI_ADDR_W + AXI_ID_W;
  localparam int MST_IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_arb_state_e;

endpackage

// File: rtl/axi_crossbar_rr_arb.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module axi_crossbar_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NUM_REQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/axi_crossbar_wr_arb.sv
// Write-path arbiter for one crossbar slave port: round-robin AW grant,
// W steering from the owner until wlast, and ID-routed B return.
module axi_crossbar_wr_arb #(
  parameter int NUM_MST    = 4,
  parameter int AXI_ADDR_W = axi_crossbar_pkg::AXI_ADDR_W,
  parameter int AXI_ID_W   = axi_crossbar_pkg::AXI_ID_W,
  parameter int AWCH_W     = axi_crossbar_pkg::AWCH_W,
  parameter int WCH_W      = axi_crossbar_pkg::WCH_W,
  parameter int BCH_W      = axi_crossbar_pkg::BCH_W
) (
  input  logic                      i_aclk,
  input  logic                      i_aresetn,
  input  logic [NUM_MST-1:0]        m_awvalid,
  output logic [NUM_MST-1:0]        m_awready,
  input  logic [NUM_MST*AWCH_W-1:0] m_awch,
  input  logic [NUM_MST-1:0]        m_wvalid,
  output logic [NUM_MST-1:0]        m_wready,
  input  logic [NUM_MST-1:0]        m_wlast,
  input  logic [NUM_MST*WCH_W-1:0]  m_wch,
  output logic [NUM_MST-1:0]        m_bvalid,
  input  logic [NUM_MST-1:0]        m_bready,
  output logic [BCH_W-1:0]          m_bch,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [AWCH_W-1:0]         s_awch,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic                      s_wlast,
  output logic [WCH_W-1:0]          s_wch,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic [BCH_W-1:0]          s_bch,
  output logic [NUM_MST-1:0]        o_grant,
  output logic [1:0]                o_err
);

  import axi_crossbar_pkg::*;

  localparam int LEN_OFF = AXI_ADDR_W + AXI_ID_W;

  wr_arb_state_e          state_p0, state_nx;
  logic [MST_IDX_W-1:0]   rr_ptr_p0, grant_idx_p0, arb_idx, next_ptr;
  logic [NUM_MST-1:0]     arb_gnt;
  logic                   arb_any;
  logic [3:0]             awlen_p0, beat_cnt_p0;
  logic [AWCH_W-1:0]      awch_p0, win_awch;
  logic [1:0]             err_p0;
  logic                   g_wvalid, g_wlast, w_hs, aw_take;
  logic [WCH_W-1:0]       g_wch;
  logic [MST_IDX_W-1:0]   b_sel;
  logic                   b_sel_ok, b_drop_hs;

  axi_crossbar_rr_arb #(
    .NUM_REQ (NUM_MST),
    .IDX_W   (MST_IDX_W)
  ) u_rr_arb (
    .req (m_awvalid),
    .ptr (rr_ptr_p0),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    win_awch = '0;
    g_wvalid = 1'b0;
    g_wlast  = 1'b0;
    g_wch    = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (arb_idx == MST_IDX_W'(i))
        win_awch = m_awch[i*AWCH_W +: AWCH_W];
      if (grant_idx_p0 == MST_IDX_W'(i)) begin
        g_wvalid = m_wvalid[i];
        g_wlast  = m_wlast[i];
        g_wch    = m_wch[i*WCH_W +: WCH_W];
      end
    end
  end

  assign aw_take   = (state_p0 == IDLE) && arb_any;
  assign w_hs      = (state_p0 == DATA) && g_wvalid && s_wready;
  assign next_ptr  = (int'(arb_idx) == NUM_MST - 1) ? '0 : arb_idx + 1'b1;

  assign m_awready = (state_p0 == IDLE) ? arb_gnt : '0;
  assign s_awvalid = (state_p0 == ADDR);
  assign s_awch    = awch_p0;
  assign s_wvalid  = (state_p0 == DATA) && g_wvalid;
  assign s_wlast   = (state_p0 == DATA) && g_wlast;
  assign s_wch     = g_wch;
  assign o_err     = err_p0;

  always_comb begin
    m_wready = '0;
    o_grant  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (state_p0 != IDLE && grant_idx_p0 == MST_IDX_W'(i)) begin
        o_grant[i]  = 1'b1;
        m_wready[i] = (state_p0 == DATA) && s_wready;
      end
    end
  end

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (arb_any) state_nx = ADDR;
      ADDR:    if (s_awready) state_nx = DATA;
      DATA:    if (w_hs && g_wlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // B return: upper ID bits select the master; unknown indices are drained.
  assign b_sel     = s_bch[AXI_ID_W-1 -: MST_IDX_W];
  assign b_sel_ok  = int'(b_sel) < NUM_MST;
  assign b_drop_hs = s_bvalid && !b_sel_ok;
  assign m_bch     = s_bch;

  always_comb begin
    m_bvalid = '0;
    s_bready = !b_sel_ok;
    for (int i = 0; i < NUM_MST; i++) begin
      if (b_sel == MST_IDX_W'(i)) begin
        m_bvalid[i] = s_bvalid;
        s_bready    = m_bready[i];
      end
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_p0     <= IDLE;
      rr_ptr_p0    <= '0;
      grant_idx_p0 <= '0;
      awch_p0      <= '0;
      awlen_p0     <= '0;
      beat_cnt_p0  <= '0;
      err_p0       <= '0;
    end else begin
      state_p0 <= state_nx;
      if (aw_take) begin
        awch_p0      <= win_awch;
        grant_idx_p0 <= arb_idx;
        awlen_p0     <= win_awch[LEN_OFF +: 4];
        beat_cnt_p0  <= '0;
        rr_ptr_p0    <= next_ptr;
      end
      if (w_hs) begin
        beat_cnt_p0 <= beat_cnt_p0 + 1'b1;
        // Early wlast and missing wlast at the final beat are both length errors.
        if (g_wlast ? (beat_cnt_p0 != awlen_p0) : (beat_cnt_p0 == awlen_p0))
          err_p0[0] <= 1'b1;
      end
      if (b_drop_hs)
        err_p0[1] <= 1'b1;
    end
  end

endmodule
